// File: rtl/param_mode_register_if.sv
// Handshake bundle for param_mode_register: op request, amount and bus-drive control,
// plus the busy/done/err status returned by the register.
interface param_mode_register_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             output_control;
    logic [2:0]       mode_input;
    logic [AMT_W-1:0] amt;
    logic             start;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output output_control, mode_input, amt, start,
        input  busy, done, err
    );

    modport slave (
        input  output_control, mode_input, amt, start,
        output busy, done, err
    );
endinterface

// File: rtl/param_mode_register.sv
// Multi-mode register on a shared tri-state bus: load, multi-cycle rotate, Gray up/down count,
// invert, half-swap, with a start/busy/done handshake. Optional PARITY_EN adds an even-parity output.
module param_mode_register #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    inout  wire  [WIDTH-1:0]       io_bus,
`ifdef PARITY_EN
    output logic                   parity,
`endif
    param_mode_register_if.slave   bus
);
    localparam int AMT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_ROR  = 3'b001;
    localparam logic [2:0] M_ROL  = 3'b010;
    localparam logic [2:0] M_GUP  = 3'b011;
    localparam logic [2:0] M_GDN  = 3'b100;
    localparam logic [2:0] M_INV  = 3'b101;
    localparam logic [2:0] M_SWAP = 3'b110;
    localparam logic [2:0] M_LOAD = 3'b111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] out_reg;
    logic [AMT_W-1:0] cnt;
    logic             rot_left;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] rot_val;
    logic             is_rot;
    logic             is_gray;
    logic             load_rej;

    function automatic logic [WIDTH-1:0] gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    assign io_bus = bus.output_control ? out_reg : 'z;

`ifdef PARITY_EN
    assign parity = ^out_reg;
`endif

    assign is_rot   = (bus.mode_input == M_ROR) || (bus.mode_input == M_ROL);
    assign is_gray  = (bus.mode_input == M_GUP) || (bus.mode_input == M_GDN);
    assign load_rej = (bus.mode_input == M_LOAD) && bus.output_control;
    assign rot_val  = rot_left ? {acc[WIDTH-2:0], acc[WIDTH-1]} : {acc[0], acc[WIDTH-1:1]};

    // Result of a single-cycle op; rotates (and amt=0 rotates) leave acc untouched here.
    always_comb begin
        acc_next = acc;
        case (bus.mode_input)
            M_HOLD, M_ROR, M_ROL: acc_next = acc;
            M_GUP:  acc_next = acc + STEP_W;
            M_GDN:  acc_next = acc - STEP_W;
            M_INV:  acc_next = ~acc;
            M_SWAP: acc_next = {acc[WIDTH/2-1:0], acc[WIDTH-1:WIDTH/2]};
            M_LOAD: acc_next = bus.output_control ? acc : io_bus;
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            out_reg  <= '0;
            cnt      <= '0;
            rot_left <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rot_left <= (bus.mode_input == M_ROL);
                        bus.busy <= 1'b1;
                        if (is_rot && (bus.amt != '0)) begin
                            cnt   <= bus.amt;
                            state <= SHIFT;
                        end else begin
                            acc      <= acc_next;
                            out_reg  <= is_gray ? gray(acc_next) : acc_next;
                            bus.err  <= load_rej;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc <= rot_val;
                    cnt <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) begin
                        out_reg  <= rot_val;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
